// File: rtl/mem_stage_if.sv
// ============================================================================
// mem_stage_if : execute-to-memory bundle and write-back bus for mem_stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_stage_if;
    logic        valid_in;
    logic [31:0] branch_target;
    logic        zero_flag;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        Branch;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        MemtoReg;
    logic [4:0]  wr_reg;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_pc;
    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        addr_err;

    modport master (
        output valid_in, branch_target, zero_flag, alu_result, store_data,
               Branch, MemRead, MemWrite, RegWrite, MemtoReg, wr_reg,
        input  stall, pc_src, branch_pc, wb_valid, wb_regwrite, wb_reg,
               wb_data, addr_err
    );

    modport slave (
        input  valid_in, branch_target, zero_flag, alu_result, store_data,
               Branch, MemRead, MemWrite, RegWrite, MemtoReg, wr_reg,
        output stall, pc_src, branch_pc, wb_valid, wb_regwrite, wb_reg,
               wb_data, addr_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : MIPS32 MEM stage - branch resolve, latency-modelled data memory,
//             registered write-back. Optional macro: MISALIGN_TRAP_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 2
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    mem_stage_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] C_LAT_LOAD = CW'(MEM_LAT - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_next_state;
    logic [CW-1:0] r_cnt;

    logic [AW-1:0] r_idx;
    logic [31:0]   r_alu;
    logic [31:0]   r_sdata;
    logic          r_is_store;
    logic          r_is_load;
    logic          r_memtoreg;
    logic          r_regwrite;
    logic [4:0]    r_wr_reg;

    logic [31:0]   r_mem [DEPTH];

    logic          r_pc_src;
    logic [31:0]   r_branch_pc;
    logic          r_wb_valid;
    logic          r_wb_regwrite;
    logic [4:0]    r_wb_reg;
    logic [31:0]   r_wb_data;

    logic          w_stall;
    logic          w_accept;
    logic          w_mem_op;
    logic          w_misalign;
    logic          w_long_op;
    logic          w_done;

    always_comb begin
        w_mem_op  = bus.MemRead | bus.MemWrite;
`ifdef MISALIGN_TRAP_EN
        w_misalign = w_mem_op & (|bus.alu_result[1:0]);
`else
        w_misalign = 1'b0;
`endif
        w_long_op = w_mem_op & ~w_misalign;
        w_accept  = bus.valid_in & ~w_stall;
        w_done    = (r_state == S_BUSY) && (r_cnt == '0);
    end

    // State register, latency counter and the bundle captured at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_alu      <= '0;
            r_sdata    <= '0;
            r_is_store <= 1'b0;
            r_is_load  <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_wr_reg   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept && w_long_op) begin
                r_cnt <= C_LAT_LOAD;
            end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_accept) begin
                r_idx      <= bus.alu_result[AW+1:2];
                r_alu      <= bus.alu_result;
                r_sdata    <= bus.store_data;
                r_is_store <= bus.MemWrite;
                r_is_load  <= bus.MemRead & ~bus.MemWrite;
                r_memtoreg <= bus.MemtoReg;
                r_regwrite <= bus.RegWrite;
                r_wr_reg   <= bus.wr_reg;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_long_op) w_next_state = S_BUSY;
            S_BUSY:  if (r_cnt == '0)           w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_stall = (r_state == S_BUSY);
    end

    // Memory has no reset; a store aborted by reset never reaches w_done
    always_ff @(posedge clk) begin
        if (w_done && r_is_store) begin
            r_mem[r_idx] <= r_sdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_src      <= 1'b0;
            r_branch_pc   <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_reg      <= '0;
            r_wb_data     <= '0;
        end else begin
            r_pc_src      <= w_accept & bus.Branch & bus.zero_flag;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            if (w_accept) begin
                r_branch_pc <= bus.branch_target;
            end
            if (w_accept && !w_long_op) begin
                r_wb_valid    <= 1'b1;
                r_wb_data     <= bus.alu_result;
                r_wb_regwrite <= bus.RegWrite & ~w_misalign;
                r_wb_reg      <= bus.wr_reg;
            end else if (w_done) begin
                r_wb_valid    <= 1'b1;
                r_wb_data     <= (r_is_load && r_memtoreg) ? r_mem[r_idx] : r_alu;
                r_wb_regwrite <= r_regwrite & ~r_is_store;
                r_wb_reg      <= r_wr_reg;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_addr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_accept & w_misalign;
        end
    end

    assign bus.addr_err = r_addr_err;
`else
    assign bus.addr_err = 1'b0;
`endif

    assign bus.stall       = w_stall;
    assign bus.pc_src      = r_pc_src;
    assign bus.branch_pc   = r_branch_pc;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_regwrite = r_wb_regwrite;
    assign bus.wb_reg      = r_wb_reg;
    assign bus.wb_data     = r_wb_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : table vectors, hand sequences and random ops vs a word model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

    localparam int DEPTH   = 256;
    localparam int MEM_LAT = 2;

    typedef struct {
        logic        rd, wr, m2r, rw, br, z;
        logic [4:0]  reg_n;
        logic [31:0] alu, sd, bt;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_rw, exp_pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          known   [DEPTH];

    mem_stage_if bus ();

    mem_stage #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rd, wr, m2r, rw, br, z, input logic [4:0] r,
                                input logic [31:0] alu, sd, bt, input logic cd,
                                input logic [31:0] ed, input logic erw, epc);
        vec_t v;
        v.rd = rd; v.wr = wr; v.m2r = m2r; v.rw = rw; v.br = br; v.z = z;
        v.reg_n = r; v.alu = alu; v.sd = sd; v.bt = bt;
        v.chk_data = cd; v.exp_data = ed; v.exp_rw = erw; v.exp_pc = epc;
        return v;
    endfunction

    function automatic logic misaligned(input vec_t v);
`ifdef MISALIGN_TRAP_EN
        return (v.rd || v.wr) && (v.alu[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Reference: expected write-back from the instruction-level rules
    function automatic vec_t predict(input vec_t v);
        vec_t o = v;
        logic mis = misaligned(v);
        int   w   = word_of(v.alu);
        o.exp_pc = v.br && v.z;
        o.exp_rw = v.rw && !v.wr && !mis;
        if (mis || v.wr) begin
            o.chk_data = 1'b0; o.exp_data = '0;
        end else if (v.rd && v.m2r) begin
            o.chk_data = known[w]; o.exp_data = ref_mem[w];
        end else begin
            o.chk_data = 1'b1; o.exp_data = v.alu;
        end
        return o;
    endfunction

    task automatic drive(input vec_t v);
        bus.MemRead = v.rd; bus.MemWrite = v.wr; bus.MemtoReg = v.m2r;
        bus.RegWrite = v.rw; bus.Branch = v.br; bus.zero_flag = v.z;
        bus.wr_reg = v.reg_n; bus.alu_result = v.alu;
        bus.store_data = v.sd; bus.branch_target = v.bt;
    endtask

    task automatic apply(input vec_t v);
        logic mis = misaligned(v);
        int   lat = ((v.rd || v.wr) && !mis) ? MEM_LAT + 1 : 1;
        @(negedge clk);
        drive(v);
        bus.valid_in = 1'b1;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk("stall",    bus.stall,    32'(c < lat));
            chk("wb_valid", bus.wb_valid, 32'(c == lat));
            chk("pc_src",   bus.pc_src,   (c == 1) ? 32'(v.exp_pc) : 32'd0);
            chk("addr_err", bus.addr_err, 32'((c == 1) && mis));
            if (c == 1) begin
                chk("branch_pc", bus.branch_pc, v.bt);
                bus.valid_in = 1'b0;
            end
            if (c == lat) begin
                chk("wb_reg",      bus.wb_reg,      32'(v.reg_n));
                chk("wb_regwrite", bus.wb_regwrite, 32'(v.exp_rw));
                if (v.chk_data) chk("wb_data", bus.wb_data, v.exp_data);
            end
        end
        if (v.wr && !mis) begin
            ref_mem[word_of(v.alu)] = v.sd;
            known[word_of(v.alu)]   = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        vec_t v;

        tbl[0]  = mk(0,0,0,1,0,0,5'd3, 32'h7,        32'h0,        32'h0,        1,32'h7,        1,0);
        tbl[1]  = mk(0,1,0,1,0,0,5'd0, 32'h20,       32'hCAFEF00D, 32'h0,        0,32'h0,        0,0);
        tbl[2]  = mk(1,0,1,1,0,0,5'd8, 32'h20,       32'h0,        32'h0,        1,32'hCAFEF00D, 1,0);
        tbl[3]  = mk(0,0,0,0,1,1,5'd0, 32'h1,        32'h0,        32'h00400040, 1,32'h1,        0,1);
        tbl[4]  = mk(0,0,0,0,1,0,5'd0, 32'h1,        32'h0,        32'h00400080, 1,32'h1,        0,0);
        tbl[5]  = mk(0,1,0,0,0,0,5'd0, 32'h400,      32'h5A5A5A5A, 32'h0,        0,32'h0,        0,0);
        tbl[6]  = mk(1,0,1,1,0,0,5'd9, 32'h0,        32'h0,        32'h0,        1,32'h5A5A5A5A, 1,0);
        tbl[7]  = mk(1,0,0,1,0,0,5'd10,32'h20,       32'h0,        32'h0,        1,32'h20,       1,0);
        tbl[8]  = mk(1,1,1,1,0,0,5'd0, 32'h30,       32'h12345678, 32'h0,        0,32'h0,        0,0);
        tbl[9]  = mk(1,0,1,1,0,0,5'd11,32'h30,       32'h0,        32'h0,        1,32'h12345678, 1,0);
        tbl[10] = mk(1,0,1,1,1,1,5'd12,32'h20,       32'h0,        32'h00400100, 1,32'hCAFEF00D, 1,1);

        rst_n = 1'b0;
        bus.valid_in = 1'b0;
        drive(mk(0,0,0,0,0,0,5'd0,32'h0,32'h0,32'h0,0,32'h0,0,0));
        repeat (3) @(negedge clk);
        chk("rst_stall",    bus.stall,    0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_pc_src",   bus.pc_src,   0);
        chk("rst_wb_data",  bus.wb_data,  0);
        chk("rst_branch_pc",bus.branch_pc,0);
        chk("rst_addr_err", bus.addr_err, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

`ifdef MISALIGN_TRAP_EN
        apply(predict(mk(0,1,0,1,0,0,5'd1,32'h22,32'hFFFFFFFF,32'h0,0,32'h0,0,0)));
        apply(predict(mk(1,0,1,1,0,0,5'd2,32'h20,32'h0,32'h0,0,32'h0,0,0)));
`endif

        // Reset during a store in flight: the store must not land
        apply(predict(mk(0,1,0,0,0,0,5'd0,32'h10,32'h11111111,32'h0,0,32'h0,0,0)));
        @(negedge clk);
        drive(mk(0,1,0,1,0,0,5'd7,32'h10,32'hDEADBEEF,32'h1234,0,32'h0,0,0));
        bus.valid_in = 1'b1;
        @(negedge clk);
        chk("rst_mid_stall_pre", bus.stall, 1);
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall",     bus.stall,       0);
        chk("rst_mid_wb_valid",  bus.wb_valid,    0);
        chk("rst_mid_branch_pc", bus.branch_pc,   0);
        chk("rst_mid_wb_data",   bus.wb_data,     0);
        chk("rst_mid_wb_reg",    bus.wb_reg,      0);
        chk("rst_mid_wb_rw",     bus.wb_regwrite, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apply(predict(mk(1,0,1,1,0,0,5'd4,32'h10,32'h0,32'h0,0,32'h0,0,0)));

        // Held valid_in during stall: new bundle accepted exactly once
        @(negedge clk);
        drive(mk(0,1,0,0,0,0,5'd0,32'h40,32'hA5A50F0F,32'h0,0,32'h0,0,0));
        bus.valid_in = 1'b1;
        for (int c = 1; c <= MEM_LAT + 3; c++) begin
            @(negedge clk);
            chk("hold_stall",    bus.stall,    32'(c <= MEM_LAT));
            chk("hold_wb_valid", bus.wb_valid, 32'((c == MEM_LAT + 1) || (c == MEM_LAT + 2)));
            if (c == 1) drive(mk(0,0,0,1,0,0,5'd5,32'h99,32'h0,32'h0,0,32'h0,0,0));
            if (c == MEM_LAT + 1) chk("hold_store_rw", bus.wb_regwrite, 0);
            if (c == MEM_LAT + 2) begin
                chk("hold_wb_data", bus.wb_data,     32'h99);
                chk("hold_wb_reg",  bus.wb_reg,      5);
                chk("hold_wb_rw",   bus.wb_regwrite, 1);
                bus.valid_in = 1'b0;
            end
        end
        ref_mem[word_of(32'h40)] = 32'hA5A50F0F;
        known[word_of(32'h40)]   = 1'b1;
        apply(predict(mk(1,0,1,1,0,0,5'd6,32'h40,32'h0,32'h0,0,32'h0,0,0)));

        for (int i = 0; i < 60; i++) begin
            logic [31:0] lo;
`ifdef MISALIGN_TRAP_EN
            lo = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h0;
`else
            lo = 32'($urandom_range(0, 3));
`endif
            v = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 5'($urandom),
                   ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) | lo,
                   $urandom, $urandom, 0, 32'h0, 0, 0);
            apply(predict(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
